// File: rtl/adc_input_stage_if.sv
// Settings bus shared by all configurable blocks on the receive path.
// Handshake: a write is a single cycle with serial_strobe high; serial_addr and
// serial_data are valid in that cycle only. There is no ready/backpressure, so
// the slave accepts every strobed write in the cycle it is presented.
interface adc_input_stage_if;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (output serial_strobe, output serial_addr, output serial_data);
  modport slave  (input  serial_strobe, input  serial_addr, input  serial_data);
endinterface

// File: rtl/adc_input_stage.sv
// adc_input_stage: registers both 12-bit ADC channels, widens them to 16 bits,
// optionally removes DC offset, and muxes the result onto the DDC I/Q inputs.
// It also tracks channel A magnitude and over-range count for RSSI readback.
// Optional feature macro: ADC_DC_OFFSET_EN (fixed/auto-tracking DC removal).
// Without it, stage 2 is a plain register and offset writes are ignored.
module adc_input_stage #(
  parameter logic [6:0]  ADDR_OFFSET_A = 7'd10,
  parameter logic [6:0]  ADDR_OFFSET_B = 7'd11,
  parameter logic [6:0]  ADDR_RX_MUX   = 7'd38,
  parameter logic [6:0]  ADDR_RSSI_CLR = 7'd39,
  parameter logic [11:0] RSSI_THRESH   = 12'd2000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  adc_input_stage_if.slave         sbus,
  input  logic [11:0]              rx_a_a,
  input  logic [11:0]              rx_b_a,
  output logic [15:0]              ddc0_in_i,
  output logic [15:0]              ddc0_in_q,
  output logic [3:0]               rx_numchan,
  output logic [31:0]              rssi_0
);

  logic wr_mux, wr_rssi_clr;
  assign wr_mux      = sbus.serial_strobe && (sbus.serial_addr == ADDR_RX_MUX);
  assign wr_rssi_clr = sbus.serial_strobe && (sbus.serial_addr == ADDR_RSSI_CLR);

  // Only the low byte of the mux word carries meaning; upper bits read as zero.
  logic [7:0] mux_q;

  // Mux register: written on strobe regardless of enable.
  always_ff @(posedge clock) begin
    if (reset)       mux_q <= 8'h42;
    else if (wr_mux) mux_q <= sbus.serial_data[7:0];
  end

  assign rx_numchan = mux_q[3:0];

  // Stage 1: capture raw ADC samples.
  logic [11:0] a_q, b_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (enable) begin
      a_q <= rx_a_a;
      b_q <= rx_b_a;
    end
  end

  // Widening is pure wiring, so it is applied to the registered sample.
  logic [15:0] a_w, b_w;
  assign a_w = {a_q[11], a_q, 3'b000};
  assign b_w = {b_q[11], b_q, 3'b000};

  // Stage 2 combinational result per channel.
  logic [15:0] c_a, c_b;

`ifdef ADC_DC_OFFSET_EN
  logic wr_off_a, wr_off_b;
  assign wr_off_a = sbus.serial_strobe && (sbus.serial_addr == ADDR_OFFSET_A);
  assign wr_off_b = sbus.serial_strobe && (sbus.serial_addr == ADDR_OFFSET_B);

  logic        auto_a_q, auto_b_q;
  logic [31:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;

  // Subtract in 17 bits so the saturation decision sees the true sign.
  function automatic logic [15:0] sat_sub(input logic [15:0] w, input logic [15:0] off);
    logic [16:0] diff;
    diff = {w[15], w} - {off[15], off};
    if (diff[16] != diff[15]) sat_sub = diff[16] ? 16'h8000 : 16'h7FFF;
    else                      sat_sub = diff[15:0];
  endfunction

  assign c_a = sat_sub(a_w, acc_a_q[31:16]);
  assign c_b = sat_sub(b_w, acc_b_q[31:16]);

  // Accumulator next state: an offset write reloads and beats accumulation.
  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    if (wr_off_a)                acc_a_d = {sbus.serial_data[15:0], 16'h0000};
    else if (enable && auto_a_q) acc_a_d = acc_a_q + {{16{c_a[15]}}, c_a};
    if (wr_off_b)                acc_b_d = {sbus.serial_data[15:0], 16'h0000};
    else if (enable && auto_b_q) acc_b_d = acc_b_q + {{16{c_b[15]}}, c_b};
  end

  // Offset mode bits and accumulators.
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_a_q <= 1'b0;
      auto_b_q <= 1'b0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      if (wr_off_a) auto_a_q <= sbus.serial_data[31];
      if (wr_off_b) auto_b_q <= sbus.serial_data[31];
    end
  end

  logic unused_data_bits;
  assign unused_data_bits = ^sbus.serial_data[30:16];
`else
  assign c_a = a_w;
  assign c_b = b_w;

  logic unused_data_bits;
  assign unused_data_bits = ^sbus.serial_data[31:8];
`endif

  // Stage 2 register: corrected samples.
  logic [15:0] c_a_q, c_b_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      c_a_q <= '0;
      c_b_q <= '0;
    end else if (enable) begin
      c_a_q <= c_a;
      c_b_q <= c_b;
    end
  end

  function automatic logic [15:0] pick(input logic [1:0] code, input logic [15:0] ca,
                                       input logic [15:0] cb);
    case (code)
      2'd0:    pick = ca;
      2'd1:    pick = cb;
      default: pick = 16'h0000;
    endcase
  endfunction

  // Stage 3: select and register the DDC inputs.
  logic [15:0] ddc_i_q, ddc_q_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      ddc_i_q <= '0;
      ddc_q_q <= '0;
    end else if (enable) begin
      ddc_i_q <= pick(mux_q[5:4], c_a_q, c_b_q);
      ddc_q_q <= pick(mux_q[7:6], c_a_q, c_b_q);
    end
  end

  assign ddc0_in_i = ddc_i_q;
  assign ddc0_in_q = ddc_q_q;

  // RSSI magnitude from the registered channel A sample; -2048 folds to 2047.
  logic [11:0] a_neg;
  logic [10:0] mag;
  assign a_neg = 12'd0 - a_q;
  assign mag   = (a_q == 12'h800) ? 11'd2047 : (a_q[11] ? a_neg[10:0] : a_q[10:0]);

  logic [25:0] avg_q, avg_d;
  logic [15:0] over_q, over_d;

  // RSSI next state: leaky average and saturating over-range count; clear wins.
  always_comb begin
    avg_d  = avg_q;
    over_d = over_q;
    if (enable) begin
      avg_d = avg_q + {15'd0, mag} - {10'd0, avg_q[25:10]};
      if (({1'b0, mag} >= RSSI_THRESH) && (over_q != 16'hFFFF)) over_d = over_q + 16'd1;
    end
    if (wr_rssi_clr) over_d = 16'h0000;
  end

  // RSSI state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      avg_q  <= '0;
      over_q <= '0;
    end else begin
      avg_q  <= avg_d;
      over_q <= over_d;
    end
  end

  assign rssi_0 = {over_q, avg_q[25:10]};

endmodule

// File: tb/tb_adc_input_stage.sv
// Directed testbench for adc_input_stage: reset state, pipeline latency,
// channel mux, offset handling (build dependent), RSSI, enable hold and reset.
module tb_adc_input_stage;

  localparam logic [6:0] A_OFF_A = 7'd10;
  localparam logic [6:0] A_MUX   = 7'd38;
  localparam logic [6:0] A_CLR   = 7'd39;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [11:0] rx_a_a, rx_b_a;
  logic [15:0] ddc0_in_i, ddc0_in_q;
  logic [3:0]  rx_numchan;
  logic [31:0] rssi_0;

  int n_checks = 0;
  int n_pass   = 0;

  adc_input_stage_if sbus();

  adc_input_stage dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sbus       (sbus.slave),
    .rx_a_a     (rx_a_a),
    .rx_b_a     (rx_b_a),
    .ddc0_in_i  (ddc0_in_i),
    .ddc0_in_q  (ddc0_in_q),
    .rx_numchan (rx_numchan),
    .rssi_0     (rssi_0)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [6:0] addr, input logic [31:0] data);
    sbus.serial_strobe = 1'b1;
    sbus.serial_addr   = addr;
    sbus.serial_data   = data;
    step(1);
    sbus.serial_strobe = 1'b0;
    sbus.serial_addr   = '0;
    sbus.serial_data   = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    rx_a_a = '0;
    rx_b_a = '0;
    sbus.serial_strobe = 1'b0;
    sbus.serial_addr   = '0;
    sbus.serial_data   = '0;
    step(2);
    check("rst_i", {16'd0, ddc0_in_i}, 32'h0);
    check("rst_q", {16'd0, ddc0_in_q}, 32'h0);
    check("rst_numchan", {28'd0, rx_numchan}, 32'd2);
    check("rst_rssi", rssi_0, 32'h0);
    reset = 1'b0;

    // Enable low: datapath and RSSI hold, settings writes still land.
    rx_a_a = 12'h800; rx_b_a = 12'h123;
    step(1);
    rx_a_a = 12'h7FF; rx_b_a = 12'h456;
    write(A_MUX, 32'h0000_0043);
    check("hold_mux_write", {28'd0, rx_numchan}, 32'd3);
    rx_a_a = 12'h800;
    step(3);
    check("hold0_i", {16'd0, ddc0_in_i}, 32'h0);
    check("hold0_q", {16'd0, ddc0_in_q}, 32'h0);
    check("hold0_rssi", rssi_0, 32'h0);
    write(A_MUX, 32'h0000_0042);
    check("mux_restore", {28'd0, rx_numchan}, 32'd2);

    // Basic path and 3-clock latency
    enable = 1'b1;
    rx_a_a = 12'h100; rx_b_a = 12'hF00;
    step(2);
    check("latency2_i", {16'd0, ddc0_in_i}, 32'h0);
    step(1);
    check("basic_i", {16'd0, ddc0_in_i}, 32'h0800);
    check("basic_q", {16'd0, ddc0_in_q}, 32'hF800);
    check("basic_numchan", {28'd0, rx_numchan}, 32'd2);

    // Channel mux
    write(A_MUX, 32'h0000_0014);
    check("mux14_numchan", {28'd0, rx_numchan}, 32'd4);
    step(1);
    check("mux14_i", {16'd0, ddc0_in_i}, 32'hF800);
    check("mux14_q", {16'd0, ddc0_in_q}, 32'h0800);
    write(A_MUX, 32'h0000_0094);
    step(1);
    check("mux94_q_zero", {16'd0, ddc0_in_q}, 32'h0000);
    check("mux94_i", {16'd0, ddc0_in_i}, 32'hF800);
    write(A_MUX, 32'h0000_0042);
    step(1);
    check("mux42_i", {16'd0, ddc0_in_i}, 32'h0800);

    // Fixed offsets (ignored when DC removal is not built in)
    write(A_OFF_A, 32'h0000_0100);
    step(2);
`ifdef ADC_DC_OFFSET_EN
    check("off100_i", {16'd0, ddc0_in_i}, 32'h0700);
`else
    check("off100_i", {16'd0, ddc0_in_i}, 32'h0800);
`endif
    rx_a_a = 12'h7FF;
    write(A_OFF_A, 32'h0000_8000);
    step(2);
`ifdef ADC_DC_OFFSET_EN
    check("off8000_sat_i", {16'd0, ddc0_in_i}, 32'h7FFF);
`else
    check("off8000_sat_i", {16'd0, ddc0_in_i}, 32'h3FF8);
`endif
    check("off8000_q", {16'd0, ddc0_in_q}, 32'hF800);

`ifdef ADC_DC_OFFSET_EN
    // Auto-tracking: offset climbs toward the input, so I drops below 0x800.
    rx_a_a = 12'h100;
    write(A_OFF_A, 32'h8000_0000);
    step(3000);
    check("auto_decay", {31'd0, (ddc0_in_i < 16'h0800) && (ddc0_in_i > 16'h0700)}, 32'd1);
`endif
    rx_a_a = 12'h100;
    write(A_OFF_A, 32'h0000_0000);
    step(2);
    check("off_reload_i", {16'd0, ddc0_in_i}, 32'h0800);

    // RSSI: clear coincides with the first -2048 sample
    rx_a_a = 12'h800;
    write(A_CLR, 32'h0);
    check("rssi_clr0", {16'd0, rssi_0[31:16]}, 32'd0);
    step(10000);
    check("rssi_over", {16'd0, rssi_0[31:16]}, 32'd10000);
    check("rssi_avg", {31'd0, (rssi_0[15:0] >= 16'd2045) && (rssi_0[15:0] <= 16'd2049)}, 32'd1);
    check("neg_full_i", {16'd0, ddc0_in_i}, 32'hC000);
    write(A_CLR, 32'h0);
    check("rssi_clr_wins", {16'd0, rssi_0[31:16]}, 32'd0);
    step(1);
    check("rssi_over1", {16'd0, rssi_0[31:16]}, 32'd1);

    // Enable low with live state
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rx_a_a = 12'(k * 12'h155);
      rx_b_a = 12'(12'hFFF - k * 12'h0A3);
      step(1);
    end
    check("hold1_i", {16'd0, ddc0_in_i}, 32'hC000);
    check("hold1_q", {16'd0, ddc0_in_q}, 32'hF800);
    check("hold1_over", {16'd0, rssi_0[31:16]}, 32'd1);

    // Reset mid-stream, with a non-default mux to prove mux reset
    enable = 1'b1;
    rx_a_a = 12'h100;
    write(A_MUX, 32'h0000_0013);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_i", {16'd0, ddc0_in_i}, 32'h0);
    check("mid_rst_numchan", {28'd0, rx_numchan}, 32'd2);
    check("mid_rst_rssi", rssi_0, 32'h0);
    step(2);
    check("mid_rst_lat2_i", {16'd0, ddc0_in_i}, 32'h0);
    step(1);
    check("mid_rst_lat3_i", {16'd0, ddc0_in_i}, 32'h0800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
